alu_muldiv_unit: RTL and testbench

//  Parametrised multi-cycle companion to the ALU control/execute path: decodes the R-type function code
//  for MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO and executes multiply/divide iteratively, one bit per cycle.

---
 rtl/alu_muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_alu_muldiv_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_unit.sv
// HI/LO owner for MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO; iterative mult/div, one bit per cycle.
// Latency: Busy for WIDTH+1 cycles (1 on divide-by-zero), Done the cycle after; Start ignored while Busy.
module alu_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_con_Start,
    input  logic [5:0]       i_con_FuncCode,
    input  logic             i_con_Flush,
    input  logic [WIDTH-1:0] i_data_A,
    input  logic [WIDTH-1:0] i_data_B,
    output logic [WIDTH-1:0] o_data_Result,
    output logic [WIDTH-1:0] o_data_Hi,
    output logic [WIDTH-1:0] o_data_Lo,
    output logic             o_con_Busy,
    output logic             o_con_Done,
    output logic             o_con_DivZero
);
    localparam logic [5:0] F_MFHI = 6'd16;
    localparam logic [5:0] F_MTHI = 6'd17;
    localparam logic [5:0] F_MFLO = 6'd18;
    localparam logic [5:0] F_MTLO = 6'd19;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_ZDIV} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               op_div, neg_main, neg_rem;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, dz_q;

    logic             accept, is_md, is_div, is_signed, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;

    // funct 24..27 share the 0110xx prefix; bit1 selects divide, bit0 selects unsigned
    assign accept    = (state == S_IDLE) && i_con_Start && !i_con_Flush;
    assign is_md     = (i_con_FuncCode[5:2] == 4'b0110);
    assign is_div    = i_con_FuncCode[1];
    assign is_signed = ~i_con_FuncCode[0];
    assign a_neg     = is_signed & i_data_A[WIDTH-1];
    assign b_neg     = is_signed & i_data_B[WIDTH-1];
    assign a_mag     = a_neg ? -i_data_A : i_data_A;
    assign b_mag     = b_neg ? -i_data_B : i_data_B;
    assign b_zero    = (i_data_B == '0);

    // one iteration step: shift-add multiply or restoring divide on the shared accumulator
    logic [WIDTH:0]     mul_sum, div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] acc_step, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_shift >= {1'b0, opnd});
        div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];
        acc_step  = op_div ? {div_rem, acc[WIDTH-2:0], div_ge} : {mul_sum, acc[WIDTH-1:1]};
        prod_fix  = neg_main ? -acc : acc;
        quot_fix  = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept && is_md) state_nxt = (is_div && b_zero) ? S_ZDIV : S_ITER;
            S_ITER: begin
                if (i_con_Flush)                     state_nxt = S_IDLE;
                else if (cnt == CW'(WIDTH - 1))      state_nxt = S_FIX;
            end
            S_FIX:   state_nxt = S_IDLE;
            S_ZDIV:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_con_Busy = (state != S_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            op_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && is_md) begin
                        op_div   <= is_div;
                        neg_main <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        cnt      <= '0;
                        opnd     <= is_div ? b_mag : a_mag;
                        acc      <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                    end else if (accept && i_con_FuncCode == F_MTHI) begin
                        hi_q <= i_data_A;
                    end else if (accept && i_con_FuncCode == F_MTLO) begin
                        lo_q <= i_data_A;
                    end
                end
                S_ITER: if (!i_con_Flush) begin
                    acc <= acc_step;
                    cnt <= cnt + CW'(1);
                end
                S_FIX: if (!i_con_Flush) begin
                    done_q <= 1'b1;
                    if (op_div) begin
                        lo_q <= quot_fix;
                        hi_q <= rem_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                end
                S_ZDIV: if (!i_con_Flush) begin
                    done_q <= 1'b1;
                    dz_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (i_con_FuncCode)
            F_MFHI:  o_data_Result = hi_q;
            F_MFLO:  o_data_Result = lo_q;
            default: o_data_Result = '0;
        endcase
    end

    assign o_data_Hi     = hi_q;
    assign o_data_Lo     = lo_q;
    assign o_con_Done    = done_q;
    assign o_con_DivZero = dz_q;
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed vectors for alu_muldiv_unit; a scoreboard queue holds expected HI/LO/DivZero per mult/div,
// popped by a monitor on every Done pulse.
module tb_alu_muldiv_unit;
    logic        i_clk = 1'b0;
    logic        i_rst, i_con_Start, i_con_Flush;
    logic [5:0]  i_con_FuncCode;
    logic [31:0] i_data_A, i_data_B;
    logic [31:0] o_data_Result, o_data_Hi, o_data_Lo;
    logic        o_con_Busy, o_con_Done, o_con_DivZero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_fail = 0;

    alu_muldiv_unit #(.WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_con_Start(i_con_Start), .i_con_FuncCode(i_con_FuncCode),
        .i_con_Flush(i_con_Flush), .i_data_A(i_data_A), .i_data_B(i_data_B),
        .o_data_Result(o_data_Result), .o_data_Hi(o_data_Hi), .o_data_Lo(o_data_Lo),
        .o_con_Busy(o_con_Busy), .o_con_Done(o_con_Done), .o_con_DivZero(o_con_DivZero)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        if (!i_rst && o_con_Done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got Done with HI=%h LO=%h expected no Done", o_data_Hi, o_data_Lo);
            end else begin
                e = sb.pop_front();
                check("sb_hi", 64'(o_data_Hi), 64'(e.hi));
                check("sb_lo", 64'(o_data_Lo), 64'(e.lo));
                check("sb_divzero", 64'(o_con_DivZero), 64'(e.dz));
                check("sb_busy_low_at_done", 64'(o_con_Busy), 64'd0);
            end
        end
    end

    // Issue a mult/div at a negedge, count Busy cycles; optionally poke a second Start mid-op.
    task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int exp_busy, input logic [31:0] eh, input logic [31:0] el,
                          input logic edz, input int poke_at);
        int n;
        sb.push_back('{hi: eh, lo: el, dz: edz});
        i_con_Start = 1'b1; i_con_FuncCode = f; i_data_A = a; i_data_B = b;
        @(negedge i_clk);
        i_con_Start = 1'b0; i_data_A = 32'hDEADBEEF; i_data_B = 32'h0BADF00D;
        n = 0;
        while (o_con_Busy && n < 200) begin
            n++;
            if (n == poke_at) begin
                i_con_Start = 1'b1; i_con_FuncCode = 6'd24; i_data_A = 32'd3; i_data_B = 32'd3;
            end else begin
                i_con_Start = 1'b0;
            end
            @(negedge i_clk);
        end
        i_con_Start = 1'b0;
        check("busy_cycles", 64'(n), 64'(exp_busy));
    endtask

    task automatic mt(input logic [5:0] f, input logic [31:0] a);
        i_con_Start = 1'b1; i_con_FuncCode = f; i_data_A = a;
        @(negedge i_clk);
        i_con_Start = 1'b0;
        check("mt_no_busy", 64'(o_con_Busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_con_Start = 1'b0; i_con_Flush = 1'b0;
        i_con_FuncCode = 6'd16; i_data_A = '0; i_data_B = '0;
        repeat (2) @(negedge i_clk);
        check("rst_hi", 64'(o_data_Hi), 64'd0);
        check("rst_lo", 64'(o_data_Lo), 64'd0);
        check("rst_busy", 64'(o_con_Busy), 64'd0);
        check("rst_done", 64'(o_con_Done), 64'd0);
        check("rst_divzero", 64'(o_con_DivZero), 64'd0);
        check("rst_result", 64'(o_data_Result), 64'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        run_md(6'd24, 32'hFFFFFFFD, 32'd7, 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, -1);
        run_md(6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001, 1'b0, -1);
        run_md(6'd26, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, -1);
        run_md(6'd27, 32'd7, 32'd2, 33, 32'd1, 32'd3, 1'b0, -1);

        mt(6'd17, 32'hAA);
        mt(6'd19, 32'h55);
        i_con_FuncCode = 6'd16; #1 check("mfhi_result", 64'(o_data_Result), 64'hAA);
        i_con_FuncCode = 6'd18; #1 check("mflo_result", 64'(o_data_Result), 64'h55);
        i_con_FuncCode = 6'd32; #1 check("other_funct_result", 64'(o_data_Result), 64'd0);

        run_md(6'd26, 32'd5, 32'd0, 1, 32'hAA, 32'h55, 1'b1, -1);
        run_md(6'd26, 32'h80000000, 32'hFFFFFFFF, 33, 32'd0, 32'h80000000, 1'b0, 5);

        // flush mid-multiply; mflo during Busy reads the old LO
        i_con_Start = 1'b1; i_con_FuncCode = 6'd24; i_data_A = 32'd5; i_data_B = 32'd5;
        @(negedge i_clk);
        i_con_Start = 1'b0; i_con_FuncCode = 6'd18;
        #1 check("mflo_while_busy", 64'(o_data_Result), 64'h80000000);
        check("busy_before_flush", 64'(o_con_Busy), 64'd1);
        repeat (9) @(negedge i_clk);
        i_con_Flush = 1'b1;
        @(negedge i_clk);
        i_con_Flush = 1'b0;
        check("flush_busy", 64'(o_con_Busy), 64'd0);
        check("flush_done", 64'(o_con_Done), 64'd0);
        check("flush_hi", 64'(o_data_Hi), 64'd0);
        check("flush_lo", 64'(o_data_Lo), 64'h80000000);

        // flush and start together in IDLE: start dropped
        i_con_Start = 1'b1; i_con_Flush = 1'b1; i_con_FuncCode = 6'd24;
        @(negedge i_clk);
        i_con_Start = 1'b0; i_con_Flush = 1'b0;
        check("flush_start_busy", 64'(o_con_Busy), 64'd0);

        // reset mid second multiply
        i_con_Start = 1'b1; i_con_FuncCode = 6'd24; i_data_A = 32'd2; i_data_B = 32'd2;
        @(negedge i_clk);
        i_con_Start = 1'b0;
        repeat (5) @(negedge i_clk);
        check("pre_rst_busy", 64'(o_con_Busy), 64'd1);
        check("pre_rst_lo", 64'(o_data_Lo), 64'h80000000);
        i_rst = 1'b1;
        #1;
        check("midop_rst_busy", 64'(o_con_Busy), 64'd0);
        check("midop_rst_hi", 64'(o_data_Hi), 64'd0);
        check("midop_rst_lo", 64'(o_data_Lo), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("post_rst_done", 64'(o_con_Done), 64'd0);

        run_md(6'd25, 32'd6, 32'd7, 33, 32'd0, 32'd42, 1'b0, -1);
        run_md(6'd26, 32'hFFFFFFF8, 32'd3, 33, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, -1);

        repeat (3) @(negedge i_clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
